// File: rtl/pwm_sample_feeder_if.sv
// FIFO-side and pwmdac-side signals of the sample feeder.
// master drives enable and FIFO status; slave is the feeder itself.
interface pwm_sample_feeder_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8
);
  logic                 enable;
  logic [IN_WIDTH-1:0]  fifo_data;
  logic                 fifo_empty_n;
  logic                 fifo_rd;
  logic [OUT_WIDTH-1:0] sample;
  logic                 sample_valid;
  logic                 underrun;
  logic [15:0]          underrun_cnt;

  modport master (
    output enable, fifo_data, fifo_empty_n,
    input  fifo_rd, sample, sample_valid,
    input  underrun, underrun_cnt
  );

  modport slave (
    input  enable, fifo_data, fifo_empty_n,
    output fifo_rd, sample, sample_valid,
    output underrun, underrun_cnt
  );
endinterface

// File: rtl/pwm_sample_feeder.sv
// Paces FIFO samples into pwmdac at a fixed rate with one-word prefetch,
// round/saturate scaling and underrun accounting.
module pwm_sample_feeder #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 4,
  parameter int PERIOD    = 2500,
  parameter int GUARD     = 2
) (
  input logic clk,
  input logic rst_n,
  pwm_sample_feeder_if.slave bus
);

  localparam int CW = $clog2(PERIOD);
  localparam int GW = $clog2(GUARD + 1);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [GW-1:0] GEND = GW'(GUARD - 1);
  localparam logic [OUT_WIDTH-1:0] MID =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [IN_WIDTH:0] HALF =
    (IN_WIDTH+1)'(1 << (SHIFT - 1));
  localparam logic [IN_WIDTH:0] MAXV =
    (IN_WIDTH+1)'((1 << OUT_WIDTH) - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ACK,
    S_SETTLE,
    S_FULL
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic [IN_WIDTH-1:0]  buf_q, buf_d;
  logic                 rd_q, rd_d;
  logic [OUT_WIDTH-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 ur_q, ur_d;
  logic [15:0]          urc_q, urc_d;

  logic                 tick;
  logic [IN_WIDTH:0]    rnd;
  logic [OUT_WIDTH-1:0] conv;

  // One extra bit so rounding of a full-scale word cannot wrap.
  always_comb begin
    rnd  = ({1'b0, buf_q} + HALF) >> SHIFT;
    conv = (rnd > MAXV) ? MAXV[OUT_WIDTH-1:0]
                        : rnd[OUT_WIDTH-1:0];
  end

  assign tick = (cnt_q == LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    guard_d  = guard_q;
    buf_d    = buf_q;
    rd_d     = 1'b0;
    sample_d = sample_q;
    valid_d  = 1'b0;
    ur_d     = 1'b0;
    urc_d    = urc_q;

    if (!bus.enable) begin
      state_d  = S_EMPTY;
      cnt_d    = '0;
      guard_d  = '0;
      buf_d    = '0;
      sample_d = MID;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);

      unique case (state_q)
        S_EMPTY: begin
          if (bus.fifo_empty_n) begin
            buf_d   = bus.fifo_data;
            rd_d    = 1'b1;
            state_d = S_ACK;
          end
        end
        S_ACK: begin
          guard_d = '0;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (guard_q == GEND) state_d = S_FULL;
          else guard_d = guard_q + GW'(1);
        end
        S_FULL: ;
        default: state_d = S_EMPTY;
      endcase

      // A tick without a full buffer leaves any fetch running.
      if (tick) begin
        if (state_q == S_FULL) begin
          sample_d = conv;
          valid_d  = 1'b1;
          state_d  = S_EMPTY;
        end else begin
          ur_d = 1'b1;
          if (urc_q != 16'hFFFF) urc_d = urc_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      cnt_q    <= '0;
      guard_q  <= '0;
      buf_q    <= '0;
      rd_q     <= 1'b0;
      sample_q <= MID;
      valid_q  <= 1'b0;
      ur_q     <= 1'b0;
      urc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      guard_q  <= guard_d;
      buf_q    <= buf_d;
      rd_q     <= rd_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ur_q     <= ur_d;
      urc_q    <= urc_d;
    end
  end

  assign bus.fifo_rd      = rd_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.underrun     = ur_q;
  assign bus.underrun_cnt = urc_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Scoreboard bench for pwm_sample_feeder with a small FIFO model.
// PERIOD=16, GUARD=2.
module tb_pwm_sample_feeder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pwm_sample_feeder_if #(.IN_WIDTH(16), .OUT_WIDTH(8)) ifc ();

  pwm_sample_feeder #(
    .IN_WIDTH (16),
    .OUT_WIDTH(8),
    .SHIFT    (4),
    .PERIOD   (16),
    .GUARD    (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] fq[$];
  logic [7:0]  sb[$];
  int          rd_cnt = 0;
  int          ur_seen = 0;
  logic        rd_prev = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] conv(input logic [15:0] x);
    int r;
    r = (int'(x) + 8) >> 4;
    if (r > 255) return 8'hFF;
    return r[7:0];
  endfunction

  task automatic push(input logic [15:0] w, input logic [7:0] e);
    fq.push_back(w);
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sb(input int n, input int maxc);
    for (int i = 0; i < maxc && sb.size() > n; i++) step();
    chk("drain", sb.size(), n);
  endtask

  // FIFO model and output monitor, both at the falling edge.
  always @(negedge clk) begin
    if (ifc.fifo_rd) begin
      if (fq.size() != 0) void'(fq.pop_front());
      rd_cnt++;
    end
    chk("rd_pulse", {31'b0, rd_prev & ifc.fifo_rd}, 0);
    rd_prev = ifc.fifo_rd;
    ifc.fifo_empty_n = (fq.size() != 0);
    ifc.fifo_data = (fq.size() != 0) ? fq[0] : 16'h0;
    if (ifc.underrun) ur_seen++;
    if (ifc.sample_valid) begin
      chk("sb_avail", {31'b0, sb.size() != 0}, 1);
      if (sb.size() != 0) chk("sample", ifc.sample, sb.pop_front());
    end
  end

  initial begin
    int rd0, ur0, n;
    logic [15:0] w;

    rst_n = 1'b0;
    ifc.enable = 1'b0;
    step();
    step();
    chk("rst_sample", ifc.sample, 8'h80);
    chk("rst_valid", ifc.sample_valid, 0);
    chk("rst_rd", ifc.fifo_rd, 0);
    chk("rst_ur", ifc.underrun, 0);
    chk("rst_cnt", ifc.underrun_cnt, 0);
    rst_n = 1'b1;
    step();

    // 1: preloaded word, exact pop and tick timing
    push(16'h0ABC, 8'hAC);
    step();
    ifc.enable = 1'b1;
    step();
    chk("t1_rd", ifc.fifo_rd, 1);
    repeat (13) step();
    step();
    chk("t1_novalid", ifc.sample_valid, 0);
    step();
    chk("t1_valid", ifc.sample_valid, 1);
    chk("t1_sample", ifc.sample, 8'hAC);

    // 2: rounding and saturation
    ur0 = ur_seen;
    push(16'h0FF8, 8'hFF);
    push(16'h0017, 8'h01);
    push(16'h0018, 8'h02);
    push(16'hFFFF, 8'hFF);
    wait_sb(0, 100);
    ifc.enable = 1'b0;
    chk("t2_ur", ur_seen - ur0, 0);
    step();
    chk("t2_mid", ifc.sample, 8'h80);

    // 3: empty FIFO for three periods
    rd0 = rd_cnt;
    ur0 = ur_seen;
    ifc.enable = 1'b1;
    repeat (48) step();
    chk("t3_ur", ur_seen - ur0, 3);
    chk("t3_cnt", ifc.underrun_cnt, 3);
    chk("t3_sample", ifc.sample, 8'h80);
    chk("t3_rd", rd_cnt - rd0, 0);
    ifc.enable = 1'b0;
    step();

    // 4: slow feeder, one pop per tick
    rd0 = rd_cnt;
    ur0 = ur_seen;
    ifc.enable = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          w = 16'($urandom);
          push(w, conv(w));
          repeat (8) step();
        end
      end
      begin
        step();
        wait_sb(0, 300);
      end
    join
    chk("t4_rd", rd_cnt - rd0, 8);
    chk("t4_ur", ur_seen - ur0, 0);
    ifc.enable = 1'b0;
    step();

    // 5: drop enable during SETTLE, then re-enable
    push(16'h0400, 8'h40);
    push(16'h0123, conv(16'h0123));
    step();
    ifc.enable = 1'b1;
    wait_sb(1, 40);
    for (int i = 0; i < 10 && !ifc.fifo_rd; i++) step();
    chk("t5_rd", ifc.fifo_rd, 1);
    step();
    ifc.enable = 1'b0;
    step();
    chk("t5_mid", ifc.sample, 8'h80);
    chk("t5_rd_off", ifc.fifo_rd, 0);
    chk("t5_dropped", fq.size(), 0);
    void'(sb.pop_front());
    rd0 = rd_cnt;
    repeat (20) step();
    chk("t5_no_rd", rd_cnt - rd0, 0);
    push(16'h0C80, 8'hC8);
    step();
    ifc.enable = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ifc.sample_valid) begin
        n = i;
        break;
      end
    end
    chk("t5_lat", n, 16);

    // 6: async reset while in SETTLE
    push(16'h0555, 8'h55);
    for (int i = 0; i < 10 && !ifc.fifo_rd; i++) step();
    chk("t6_rd", ifc.fifo_rd, 1);
    step();
    chk("t6_pre_cnt", ifc.underrun_cnt, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_sample", ifc.sample, 8'h80);
    chk("t6_valid", ifc.sample_valid, 0);
    chk("t6_rd0", ifc.fifo_rd, 0);
    chk("t6_ur", ifc.underrun, 0);
    chk("t6_cnt", ifc.underrun_cnt, 0);
    void'(sb.pop_front());
    ifc.enable = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    push(16'h0777, 8'h77);
    step();
    ifc.enable = 1'b1;
    wait_sb(0, 40);
    chk("t6_after", ifc.sample, 8'h77);
    ifc.enable = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
